// File: rtl/seg_pkg.sv
// Shared constants for the stopwatch display path: segment width, active-low
// glyph codes {g,f,e,d,c,b,a}, and the BCD-to-glyph lookup.
package seg_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Codes 10-15 are not valid BCD and render as a lone dash.
    function automatic logic [SEG_W-1:0] bcd2seg(input logic [3:0] bcd);
        logic [SEG_W-1:0] glyph;
        case (bcd)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_DASH;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low 7-segment glyph decoder.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0]       bcd,
    output logic [SEG_W-1:0] seg
);

    assign seg = bcd2seg(bcd);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with a once-per-frame digit snapshot.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*DIGITS-1:0] digits,
    input  logic [DIGITS-1:0]   dp_mask,
    output logic [DIGITS-1:0]   an,
    output logic [SEG_W-1:0]    seg,
    output logic                dp,
    output logic                frame_tick
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0] presc_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [3:0]       shadow_reg [DIGITS];
    logic [DIGITS-1:0] shadow_dp_reg;

    logic [DIGITS-1:0] an_reg;
    logic [SEG_W-1:0]  seg_reg;
    logic              dp_reg;
    logic              frame_tick_reg;

    logic              slot_tick;
    logic              frame_wrap;
    logic [3:0]        cur_digit;
    logic [SEG_W-1:0]  cur_glyph;
    logic              blank_cur;

    assign slot_tick  = (presc_reg == PRESC_LAST);
    assign frame_wrap = slot_tick && (idx_reg == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg     <= '0;
            idx_reg       <= '0;
            shadow_dp_reg <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                shadow_reg[i] <= '0;
            end
        end else begin
            presc_reg <= slot_tick ? '0 : presc_reg + CNT_W'(1);
            if (slot_tick) begin
                idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
            end
            // Snapshot only at the frame boundary so a counter carry never tears a frame.
            if (frame_wrap) begin
                shadow_dp_reg <= dp_mask;
                for (int i = 0; i < DIGITS; i++) begin
                    shadow_reg[i] <= digits[4*i +: 4];
                end
            end
        end
    end

    assign cur_digit = shadow_reg[idx_reg];

    bcd_to_seg u_bcd_to_seg (
        .bcd (cur_digit),
        .seg (cur_glyph)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // lead_zero[i]: digit i and every more significant digit are zero.
    logic [DIGITS-1:0] lead_zero;

    assign lead_zero[DIGITS-1] = (shadow_reg[DIGITS-1] == 4'd0);
    for (genvar gi = 0; gi < DIGITS - 1; gi++) begin : g_lead_zero
        assign lead_zero[gi] = (shadow_reg[gi] == 4'd0) && lead_zero[gi+1];
    end

    assign blank_cur = (idx_reg != '0) && lead_zero[idx_reg];
`else
    assign blank_cur = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_reg         <= '1;
            seg_reg        <= SEG_BLANK;
            dp_reg         <= 1'b1;
            frame_tick_reg <= 1'b0;
        end else begin
            an_reg         <= ~(DIGITS'(1) << idx_reg);
            seg_reg        <= blank_cur ? SEG_BLANK : cur_glyph;
            dp_reg         <= ~shadow_dp_reg[idx_reg];
            frame_tick_reg <= frame_wrap;
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign frame_tick = frame_tick_reg;

endmodule
